// File: rtl/engine_m_axi_burst_sequencer.sv
// Splits a beat-counted job into 4KB-safe AXI bursts and deals them
// round-robin across command channels with per-channel outstanding limits.
module engine_m_axi_burst_sequencer #(
  parameter int NUM_CHANNELS    = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int BEAT_BYTES      = 64,
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    start_in,
  input  logic [ADDR_WIDTH-1:0]   base_addr_in,
  input  logic [31:0]             num_beats_in,
  output logic [NUM_CHANNELS-1:0] cmd_valid_out,
  input  logic [NUM_CHANNELS-1:0] cmd_ready_in,
  output logic [ADDR_WIDTH-1:0]   cmd_addr_out,
  output logic [7:0]              cmd_len_out,
  input  logic [NUM_CHANNELS-1:0] resp_done_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [4:0]              state_out,
  output logic                    resp_err_out
);

  localparam int BB_LG = $clog2(BEAT_BYTES);
  localparam int PW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [4:0] {
    S_RESET = 5'b00001,
    S_READY = 5'b00010,
    S_CMD   = 5'b00100,
    S_PEND  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [31:0]           r_rem;
  logic [PW-1:0]         r_ptr;
  logic [CW-1:0]         r_cnt [NUM_CHANNELS];
  logic                  r_err;

  logic [NUM_CHANNELS-1:0] w_valid;
  logic                    w_hs;
  logic [8:0]              w_beats;
  logic [31:0]             w_rem_nxt;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [7:0]              w_next_len;
  logic [7:0]              w_first_len;
  logic [CW-1:0]           w_cnt_nxt [NUM_CHANNELS];
  logic                    w_err_nxt;
  logic                    w_all_zero;

  // Burst size: limited by job remainder, max burst and distance to 4KB.
  function automatic logic [8:0] f_beats(input logic [11:0] a,
                                         input logic [31:0] rem);
    logic [31:0] n;
    logic [31:0] lim;
    lim = (32'd4096 - {20'd0, a}) >> BB_LG;
    n   = rem;
    if (n > 32'(MAX_BURST_BEATS)) n = 32'(MAX_BURST_BEATS);
    if (n > lim) n = lim;
    return n[8:0];
  endfunction

  always_comb begin
    w_valid = '0;
    if (r_state == S_CMD && r_cnt[r_ptr] < CW'(MAX_OUTSTANDING))
      w_valid[r_ptr] = 1'b1;
  end

  assign w_hs        = |(w_valid & cmd_ready_in);
  assign w_beats     = {1'b0, r_len} + 9'd1;
  assign w_rem_nxt   = r_rem - 32'(w_beats);
  assign w_addr_nxt  = r_addr + (ADDR_WIDTH'(w_beats) << BB_LG);
  assign w_next_len  = 8'(f_beats(w_addr_nxt[11:0], w_rem_nxt) - 9'd1);
  assign w_first_len = 8'(f_beats(base_addr_in[11:0], num_beats_in) - 9'd1);

  always_comb begin
    logic v_inc;
    w_err_nxt  = r_err;
    w_all_zero = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      v_inc        = w_hs && (r_ptr == PW'(c));
      w_cnt_nxt[c] = r_cnt[c];
      if (v_inc && !resp_done_in[c])
        w_cnt_nxt[c] = r_cnt[c] + 1'b1;
      else if (!v_inc && resp_done_in[c]) begin
        if (r_cnt[c] != '0) w_cnt_nxt[c] = r_cnt[c] - 1'b1;
        else                w_err_nxt    = 1'b1;
      end
      if (w_cnt_nxt[c] != '0) w_all_zero = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state <= S_RESET;
      r_addr  <= '0;
      r_len   <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_cnt[c] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
      unique case (r_state)
        S_RESET: r_state <= S_READY;
        S_READY: begin
          if (start_in) begin
            if (num_beats_in == '0) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= base_addr_in;
              r_rem   <= num_beats_in;
              r_len   <= w_first_len;
              r_ptr   <= '0;
              r_state <= S_CMD;
            end
          end
        end
        S_CMD: begin
          if (w_hs) begin
            r_rem  <= w_rem_nxt;
            r_addr <= w_addr_nxt;
            r_ptr  <= (r_ptr == PW'(NUM_CHANNELS - 1)) ? '0 : r_ptr + 1'b1;
            if (w_rem_nxt == '0) r_state <= S_PEND;
            else                 r_len   <= w_next_len;
          end
        end
        S_PEND:  if (w_all_zero) r_state <= S_DONE;
        S_DONE:  r_state <= S_READY;
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign cmd_valid_out = w_valid;
  assign cmd_addr_out  = r_addr;
  assign cmd_len_out   = r_len;
  assign busy_out      = (r_state == S_CMD) || (r_state == S_PEND);
  assign done_out      = (r_state == S_DONE);
  assign state_out     = r_state;
  assign resp_err_out  = r_err;

endmodule

// File: tb/tb_engine_m_axi_burst_sequencer.sv
// Bench for engine_m_axi_burst_sequencer: directed jobs plus random jobs
// checked cycle by cycle against a burst-list reference model.
module tb_engine_m_axi_burst_sequencer;

  localparam int NC   = 2;
  localparam int MAXO = 2;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        start_in;
  logic [63:0] base_addr_in;
  logic [31:0] num_beats_in;
  logic [1:0]  cmd_valid_out;
  logic [1:0]  cmd_ready_in;
  logic [63:0] cmd_addr_out;
  logic [7:0]  cmd_len_out;
  logic [1:0]  resp_done_in;
  logic        busy_out;
  logic        done_out;
  logic [4:0]  state_out;
  logic        resp_err_out;

  engine_m_axi_burst_sequencer #(
    .NUM_CHANNELS(NC),
    .ADDR_WIDTH(64),
    .BEAT_BYTES(64),
    .MAX_BURST_BEATS(64),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .ap_clk(ap_clk),
    .areset(areset),
    .start_in(start_in),
    .base_addr_in(base_addr_in),
    .num_beats_in(num_beats_in),
    .cmd_valid_out(cmd_valid_out),
    .cmd_ready_in(cmd_ready_in),
    .cmd_addr_out(cmd_addr_out),
    .cmd_len_out(cmd_len_out),
    .resp_done_in(resp_done_in),
    .busy_out(busy_out),
    .done_out(done_out),
    .state_out(state_out),
    .resp_err_out(resp_err_out)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tot = 0;
  int n_bad = 0;

  // Reference model: observable state code, burst list, outstanding counts
  int                m_st;
  int                m_out [NC];
  bit                m_err;
  int                m_idx;
  int                m_cyc;
  longint unsigned   m_addr [$];
  int                m_len  [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_valid();
    logic [1:0] v;
    int ch;
    v = 2'b00;
    if (m_st == 4) begin
      ch = m_idx % NC;
      if (m_out[ch] < MAXO) v[ch] = 1'b1;
    end
    return v;
  endfunction

  task automatic build(input longint unsigned base, input int nb);
    longint unsigned a;
    int r, b, lim;
    m_addr.delete();
    m_len.delete();
    a = base;
    r = nb;
    while (r > 0) begin
      b   = (r > 64) ? 64 : r;
      lim = int'((4096 - (a % 4096)) / 64);
      if (b > lim) b = lim;
      m_addr.push_back(a);
      m_len.push_back(b - 1);
      a += longint'(b) * 64;
      r -= b;
    end
  endtask

  task automatic check_all();
    chk("valid", 64'(cmd_valid_out), 64'(exp_valid()));
    chk("state", 64'(state_out), 64'(m_st));
    chk("busy", 64'(busy_out), 64'(m_st == 4 || m_st == 8));
    chk("done", 64'(done_out), 64'(m_st == 16));
    chk("err", 64'(resp_err_out), 64'(m_err));
    if (m_st == 4) begin
      chk("addr", cmd_addr_out, m_addr[m_idx]);
      chk("len", 64'(cmd_len_out), 64'(m_len[m_idx]));
    end
  endtask

  // One clock: drive at negedge, advance model, check at next negedge
  task automatic cyc(input logic [1:0] rdy, input logic [1:0] rsp,
                     input logic st, input logic [63:0] base,
                     input logic [31:0] nb);
    logic [1:0] ev;
    bit hs, inc, all0;
    int ch;
    cmd_ready_in = rdy;
    resp_done_in = rsp;
    start_in     = st;
    base_addr_in = base;
    num_beats_in = nb;
    ev = exp_valid();
    hs = (ev & rdy) != 2'b00;
    ch = m_idx % NC;
    for (int c = 0; c < NC; c++) begin
      inc = hs && (ch == c);
      if (inc && !rsp[c]) m_out[c]++;
      else if (!inc && rsp[c]) begin
        if (m_out[c] > 0) m_out[c]--;
        else m_err = 1'b1;
      end
    end
    all0 = 1'b1;
    for (int c = 0; c < NC; c++) if (m_out[c] != 0) all0 = 1'b0;
    case (m_st)
      1: m_st = 2;
      2: if (st) begin
           if (nb == 0) m_st = 16;
           else begin
             build(base, int'(nb));
             m_idx = 0;
             m_st  = 4;
           end
         end
      4: if (hs) begin
           m_idx++;
           if (m_idx == m_addr.size()) m_st = 8;
         end
      8: if (all0) m_st = 16;
      16: m_st = 2;
      default: m_st = 1;
    endcase
    m_cyc++;
    @(negedge ap_clk);
    check_all();
  endtask

  task automatic run_job(input longint unsigned base, input int nb,
                         input bit rdy_all, input int hold);
    logic [1:0] rdy, rsp;
    int k;
    cyc(2'b00, 2'b00, 1'b1, base, 32'(nb));
    m_cyc = 0;
    k = 0;
    while (m_st != 2 && k < 3000) begin
      rdy = rdy_all ? 2'b11 : 2'($urandom);
      rsp = 2'b00;
      for (int c = 0; c < NC; c++)
        if (m_out[c] > 0 && m_cyc >= hold && ($urandom % 3) == 0)
          rsp[c] = 1'b1;
      cyc(rdy, rsp, 1'b0, 64'(0), 32'(0));
      k++;
    end
    if (m_st != 2) chk("timeout", 64'(m_st), 64'(2));
  endtask

  task automatic async_reset();
    #3 areset = 1'b1;
    #1;
    chk("rst_valid", 64'(cmd_valid_out), 64'(0));
    chk("rst_state", 64'(state_out), 64'(1));
    chk("rst_addr", cmd_addr_out, 64'(0));
    chk("rst_len", 64'(cmd_len_out), 64'(0));
    chk("rst_busy", 64'(busy_out), 64'(0));
    chk("rst_done", 64'(done_out), 64'(0));
    chk("rst_err", 64'(resp_err_out), 64'(0));
    m_st  = 1;
    m_err = 1'b0;
    m_idx = 0;
    for (int c = 0; c < NC; c++) m_out[c] = 0;
    @(negedge ap_clk);
    areset = 1'b0;
    check_all();
  endtask

  initial begin
    longint unsigned b;
    int nb;
    areset       = 1'b1;
    start_in     = 1'b0;
    base_addr_in = '0;
    num_beats_in = '0;
    cmd_ready_in = '0;
    resp_done_in = '0;
    m_st  = 1;
    m_err = 1'b0;
    m_idx = 0;
    m_cyc = 0;
    for (int c = 0; c < NC; c++) m_out[c] = 0;
    #1;
    chk("por_state", 64'(state_out), 64'(1));
    chk("por_valid", 64'(cmd_valid_out), 64'(0));
    chk("por_addr", cmd_addr_out, 64'(0));
    @(negedge ap_clk);
    areset = 1'b0;
    check_all();
    cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));

    run_job(64'h0FC0, 3, 1'b1, 0);
    run_job(64'h0, 130, 1'b1, 0);
    run_job(64'h40, 0, 1'b1, 0);
    run_job(64'h0, 512, 1'b1, 12);

    cyc(2'b00, 2'b00, 1'b1, 64'h0, 32'd200);
    cyc(2'b01, 2'b00, 1'b0, 64'(0), 32'(0));
    cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));
    cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));
    chk("pre_rst_ch1", 64'(cmd_valid_out), 64'(2'b10));
    async_reset();
    cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));

    for (int j = 0; j < 30; j++) begin
      b  = (64'($urandom_range(0, 255)) << 12) +
           (64'($urandom_range(0, 63)) << 6);
      nb = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 300));
      run_job(b, nb, ($urandom % 4) == 0, int'($urandom_range(0, 6)));
      if (($urandom % 2) == 0) cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));
    end

    cyc(2'b00, 2'b10, 1'b0, 64'(0), 32'(0));
    chk("err_set", 64'(resp_err_out), 64'(1));
    for (int j = 0; j < 3; j++) cyc(2'b00, 2'b00, 1'b0, 64'(0), 32'(0));
    run_job(64'h1000, 5, 1'b1, 0);
    chk("err_sticky", 64'(resp_err_out), 64'(1));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
